calendario_fecha: RTL and testbench

Date source for the date-comparison path. It holds the current day/month and drives the `dia`/`mes` bus that the Comparador consumes. It advances one day per `avance_dia` strobe, honours month lengths and leap years through an internal year-mod-4 counter, and accepts a validated parallel load. A one-cycle `fecha_nueva` strobe tells the downstream comparator when to sample.

---
 rtl/calendario_fecha_pkg.sv | 31 +++
 rtl/calendario_fecha_dias_del_mes.sv | 21 ++
 rtl/calendario_fecha.sv | 106 ++++++++++
 tb/tb_calendario_fecha.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/calendario_fecha_pkg.sv
// Shared definitions for the calendar date source: field widths, month
// numbers, month lengths and controller state encodings.
package calendario_fecha_pkg;

  localparam int ANCHO_DIA = 5;
  localparam int ANCHO_MES = 4;

  localparam logic [ANCHO_MES-1:0] ENE = 4'd1;
  localparam logic [ANCHO_MES-1:0] FEB = 4'd2;
  localparam logic [ANCHO_MES-1:0] MAR = 4'd3;
  localparam logic [ANCHO_MES-1:0] ABR = 4'd4;
  localparam logic [ANCHO_MES-1:0] MAY = 4'd5;
  localparam logic [ANCHO_MES-1:0] JUN = 4'd6;
  localparam logic [ANCHO_MES-1:0] JUL = 4'd7;
  localparam logic [ANCHO_MES-1:0] AGO = 4'd8;
  localparam logic [ANCHO_MES-1:0] SEP = 4'd9;
  localparam logic [ANCHO_MES-1:0] OCT = 4'd10;
  localparam logic [ANCHO_MES-1:0] NOV = 4'd11;
  localparam logic [ANCHO_MES-1:0] DIC = 4'd12;

  localparam logic [ANCHO_DIA-1:0] DIAS_30      = 5'd30;
  localparam logic [ANCHO_DIA-1:0] DIAS_31      = 5'd31;
  localparam logic [ANCHO_DIA-1:0] FEB_NORMAL   = 5'd28;
  localparam logic [ANCHO_DIA-1:0] FEB_BISIESTO = 5'd29;

  typedef enum logic {
    ESPERA    = 1'b0,
    ACTUALIZA = 1'b1
  } estado_t;

endpackage

// File: rtl/calendario_fecha_dias_del_mes.sv
// Combinational month-length lookup: number of days in a month given the
// year mod 4 (0 means leap year). Out-of-range months report 31.
module dias_del_mes
  import calendario_fecha_pkg::*;
(
  input  logic [ANCHO_MES-1:0] mes,
  input  logic [1:0]           anio_mod4,
  output logic [ANCHO_DIA-1:0] dias_max
);

  // Month length table with the February leap-year special case
  always_comb begin
    dias_max = DIAS_31;
    case (mes)
      FEB:               dias_max = (anio_mod4 == 2'd0) ? FEB_BISIESTO : FEB_NORMAL;
      ABR, JUN, SEP, NOV: dias_max = DIAS_30;
      default:           dias_max = DIAS_31;
    endcase
  end

endmodule

// File: rtl/calendario_fecha.sv
// Calendar date source: holds day/month/year-mod-4, advances one day per
// strobe, accepts validated parallel loads and pulses fecha_nueva whenever
// the date bus carries a freshly updated value.
module calendario_fecha
  import calendario_fecha_pkg::*;
#(
  parameter logic [1:0] ANIO_MOD4_INI = 2'd0,
  parameter bit         CHEQUEO_CARGA = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 avance_dia,
  input  logic                 carga,
  input  logic [ANCHO_DIA-1:0] dia_in,
  input  logic [ANCHO_MES-1:0] mes_in,
  input  logic [1:0]           anio_in,
  output logic [ANCHO_DIA-1:0] dia,
  output logic [ANCHO_MES-1:0] mes,
  output logic [1:0]           anio_mod4,
  output logic                 fecha_nueva,
  output logic                 fin_mes,
  output logic                 fin_anio,
  output logic                 error_carga
);

  estado_t              estado;
  logic [ANCHO_DIA-1:0] dias_actual;
  logic [ANCHO_DIA-1:0] dias_carga;
  logic                 carga_valida;
  logic                 fecha_ilegal;

  dias_del_mes u_dias_actual (
    .mes       (mes),
    .anio_mod4 (anio_mod4),
    .dias_max  (dias_actual)
  );

  dias_del_mes u_dias_carga (
    .mes       (mes_in),
    .anio_mod4 (anio_in),
    .dias_max  (dias_carga)
  );

  // Load acceptance: range check on month, then day against that month's length
  always_comb begin
    carga_valida = 1'b1;
    if (CHEQUEO_CARGA) begin
      carga_valida = (mes_in >= ENE) && (mes_in <= DIC) &&
                     (dia_in >= 5'd1) && (dia_in <= dias_carga);
    end
  end

  assign fecha_ilegal = (mes < ENE) || (mes > DIC) || (dia == 5'd0);

  // ACTUALIZA is held exactly in the cycles that follow an accepted strobe
  assign fecha_nueva = (estado == ACTUALIZA);

  // Controller and date registers; load takes priority over advance
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      estado      <= ESPERA;
      dia         <= 5'd1;
      mes         <= ENE;
      anio_mod4   <= ANIO_MOD4_INI;
      fin_mes     <= 1'b0;
      fin_anio    <= 1'b0;
      error_carga <= 1'b0;
    end else begin
      fin_mes     <= 1'b0;
      fin_anio    <= 1'b0;
      error_carga <= 1'b0;
      if (carga) begin
        if (carga_valida) begin
          estado    <= ACTUALIZA;
          dia       <= dia_in;
          mes       <= mes_in;
          anio_mod4 <= anio_in;
        end else begin
          estado      <= ESPERA;
          error_carga <= 1'b1;
        end
      end else if (avance_dia) begin
        estado <= ACTUALIZA;
        if (fecha_ilegal) begin
          dia <= 5'd1;
          mes <= ENE;
        end else if (dia < dias_actual) begin
          dia <= dia + 5'd1;
        end else if (mes < DIC) begin
          dia     <= 5'd1;
          mes     <= mes + 4'd1;
          fin_mes <= 1'b1;
        end else begin
          dia       <= 5'd1;
          mes       <= ENE;
          anio_mod4 <= anio_mod4 + 2'd1;
          fin_mes   <= 1'b1;
          fin_anio  <= 1'b1;
        end
      end else begin
        estado <= ESPERA;
      end
    end
  end

endmodule

// File: tb/tb_calendario_fecha.sv
// Bench for calendario_fecha: directed calendar scenarios followed by random
// strobes, every cycle compared against a day-of-year reference model.
module tb_calendario_fecha;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       avance_dia;
  logic       carga;
  logic [4:0] dia_in;
  logic [3:0] mes_in;
  logic [1:0] anio_in;
  logic [4:0] dia;
  logic [3:0] mes;
  logic [1:0] anio_mod4;
  logic       fecha_nueva;
  logic       fin_mes;
  logic       fin_anio;
  logic       error_carga;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int md, mm, my;
  int efn, efm, efa, eerr;

  calendario_fecha #(
    .ANIO_MOD4_INI (2'd0),
    .CHEQUEO_CARGA (1'b1)
  ) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .avance_dia  (avance_dia),
    .carga       (carga),
    .dia_in      (dia_in),
    .mes_in      (mes_in),
    .anio_in     (anio_in),
    .dia         (dia),
    .mes         (mes),
    .anio_mod4   (anio_mod4),
    .fecha_nueva (fecha_nueva),
    .fin_mes     (fin_mes),
    .fin_anio    (fin_anio),
    .error_carga (error_carga)
  );

  always #5 clk = ~clk;

  function automatic int dmax(input int m, input int y);
    if (m == 2) return (y == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    if (m >= 1 && m <= 12) return 31;
    return 0;
  endfunction

  // model: one clock edge, date handled as day-of-year ordinal
  task automatic model_edge();
    int doy, ylen, om;
    efn = 0; efm = 0; efa = 0; eerr = 0;
    if (!reset_L) begin
      md = 1; mm = 1; my = 0;
    end else if (carga) begin
      if (mes_in >= 1 && mes_in <= 12 && dia_in >= 1 && int'(dia_in) <= dmax(mes_in, anio_in)) begin
        md = dia_in; mm = mes_in; my = anio_in; efn = 1;
      end else begin
        eerr = 1;
      end
    end else if (avance_dia) begin
      efn = 1;
      doy = md;
      for (int k = 1; k < mm; k++) doy += dmax(k, my);
      ylen = (my == 0) ? 366 : 365;
      om = mm;
      if (doy >= ylen) begin
        md = 1; mm = 1; my = (my + 1) % 4; efa = 1; efm = 1;
      end else begin
        doy = doy + 1;
        mm = 1;
        while (doy > dmax(mm, my)) begin
          doy -= dmax(mm, my);
          mm++;
        end
        md = doy;
        efm = (mm != om);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("dia", dia, md);
    chk("mes", mes, mm);
    chk("anio_mod4", anio_mod4, my);
    chk("fecha_nueva", fecha_nueva, efn);
    chk("fin_mes", fin_mes, efm);
    chk("fin_anio", fin_anio, efa);
    chk("error_carga", error_carga, eerr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  task automatic idle();
    avance_dia = 0; carga = 0;
  endtask

  task automatic advance();
    carga = 0; avance_dia = 1;
    step();
    avance_dia = 0;
  endtask

  task automatic load(input int d, input int m, input int y);
    avance_dia = 0; carga = 1;
    dia_in = 5'(d); mes_in = 4'(m); anio_in = 2'(y);
    step();
    carga = 0;
  endtask

  initial begin
    md = 1; mm = 1; my = 0;
    efn = 0; efm = 0; efa = 0; eerr = 0;
    reset_L = 0; avance_dia = 0; carga = 0;
    dia_in = 0; mes_in = 0; anio_in = 0;

    // reset state
    step();
    step();
    chk("rst_dia", dia, 1);
    chk("rst_mes", mes, 1);
    chk("rst_fn", fecha_nueva, 0);
    reset_L = 1;
    idle();
    step();

    // 59 advances to Feb 29 (leap), then roll into March
    for (int i = 0; i < 59; i++) advance();
    chk("feb29_dia", dia, 29);
    chk("feb29_mes", mes, 2);
    advance();
    chk("mar1_dia", dia, 1);
    chk("mar1_mes", mes, 3);
    chk("mar1_fin_mes", fin_mes, 1);

    // February in common and leap years
    load(28, 2, 1);
    advance();
    chk("comun_dia", dia, 1);
    chk("comun_fin_mes", fin_mes, 1);
    load(28, 2, 0);
    advance();
    chk("bis_dia", dia, 29);
    chk("bis_fin_mes", fin_mes, 0);

    // year rollover
    load(31, 12, 3);
    idle();
    step();
    advance();
    chk("anio_dia", dia, 1);
    chk("anio_mes", mes, 1);
    chk("anio_mod4", anio_mod4, 0);
    chk("anio_fin_anio", fin_anio, 1);
    chk("anio_fn", fecha_nueva, 1);

    // rejected loads leave the date alone
    load(31, 4, 0);
    chk("inv1_err", error_carga, 1);
    load(30, 2, 0);
    chk("inv2_err", error_carga, 1);
    load(5, 13, 0);
    chk("inv3_err", error_carga, 1);
    chk("inv3_fn", fecha_nueva, 0);
    chk("inv3_dia", dia, 1);

    // load beats a simultaneous advance
    load(30, 4, 1);
    carga = 1; avance_dia = 1; dia_in = 10; mes_in = 7; anio_in = 1;
    step();
    idle();
    chk("prio_dia", dia, 10);
    chk("prio_mes", mes, 7);
    chk("prio_fin_mes", fin_mes, 0);

    // reset in the middle of an advance burst
    for (int i = 0; i < 5; i++) advance();
    avance_dia = 1; reset_L = 0;
    step();
    reset_L = 1; idle();
    chk("rstmid_dia", dia, 1);
    chk("rstmid_mes", mes, 1);
    chk("rstmid_fn", fecha_nueva, 0);

    // downstream match against reference date 15/6
    load(1, 6, 2);
    for (int i = 1; i <= 20; i++) begin
      advance();
      chk("match_15_6", int'(dia == 5'd15 && mes == 4'd6 && fecha_nueva), int'(i == 14));
    end

    // random strobes, loads and occasional resets
    for (int i = 0; i < 2000; i++) begin
      reset_L    = ($urandom_range(0, 63) != 0);
      avance_dia = $urandom_range(0, 1);
      carga      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        mes_in  = 4'($urandom_range(1, 12));
        anio_in = 2'($urandom_range(0, 3));
        dia_in  = 5'($urandom_range(1, dmax(mes_in, anio_in)));
      end else begin
        dia_in  = 5'($urandom_range(0, 31));
        mes_in  = 4'($urandom_range(0, 15));
        anio_in = 2'($urandom_range(0, 3));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
